mic_frame_ctrl: RTL and testbench

- Read-side sequencer for the 128x16 mic sample FIFO.
- Drains samples from the FIFO and groups them into fixed-length frames.
- Presents frames to the downstream feature-extraction stage over a valid/ready stream, with start-of-frame and end-of-frame markers.
- Also watches the write side and flags overflow, i.e. samples lost when the mic writes while the FIFO is full.

---
 rtl/mic_frame_ctrl_if.sv | 26 ++
 rtl/mic_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_mic_frame_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mic_frame_ctrl_if.sv
// Downstream sample stream: valid/ready handshake with start/end-of-frame markers.
interface mic_frame_ctrl_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eof;

  modport master (
    output out_data,
    output out_valid,
    output out_sof,
    output out_eof,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sof,
    input  out_eof,
    output out_ready
  );
endinterface

// File: rtl/mic_frame_ctrl.sv
// Read-side sequencer for the mic sample FIFO: drains samples into fixed-length frames
// and watches the write side for overflow. MICCTRL_DROPCNT_EN builds the dropped-sample counter.
module mic_frame_ctrl #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic              mic_wr_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  mic_frame_ctrl_if.master  stream,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              ovf_flag,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    CAPT,
    PRESENT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  sample_idx;
  logic [DATA_W-1:0] data_q;
  logic              sof_q;
  logic              eof_q;
  logic              valid_c;
  logic              handshake;
  logic              drop;

  assign handshake = (state == PRESENT) && stream.out_ready;
  assign drop      = mic_wr_en && fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // One sample in flight at a time: a read is only issued from REQ, never while presenting.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    busy       = 1'b1;
    valid_c    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable && !fifo_empty) begin
          state_nxt = REQ;
        end
      end
      WAIT: begin
        if (!fifo_empty) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        fifo_rd_en = 1'b1;
        state_nxt  = CAPT;
      end
      CAPT: begin
        state_nxt = PRESENT;
      end
      PRESENT: begin
        valid_c = 1'b1;
        if (stream.out_ready) begin
          if (eof_q) begin
            state_nxt = (enable && !fifo_empty) ? REQ : IDLE;
          end else begin
            state_nxt = fifo_empty ? WAIT : REQ;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      sample_idx <= '0;
      frame_cnt  <= '0;
    end else begin
      if (state == CAPT) begin
        data_q <= fifo_dout;
        sof_q  <= (sample_idx == '0);
        eof_q  <= (sample_idx == LAST_IDX);
      end
      if (handshake) begin
        if (eof_q) begin
          sample_idx <= '0;
          frame_cnt  <= frame_cnt + CNT_W'(1);
        end else begin
          sample_idx <= sample_idx + IDX_W'(1);
        end
      end
    end
  end

  assign stream.out_data  = data_q;
  assign stream.out_sof   = sof_q;
  assign stream.out_eof   = eof_q;
  assign stream.out_valid = valid_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (drop) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
    end
  end

`ifdef MICCTRL_DROPCNT_EN
  // A clear coinciding with a drop restarts the count at one rather than zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (ovf_clr) begin
        drop_cnt <= CNT_W'(1);
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end else if (ovf_clr) begin
      drop_cnt <= '0;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mic_frame_ctrl.sv
// Directed bench for mic_frame_ctrl: a FRAME_LEN=4 instance and a FRAME_LEN=1 instance,
// each fed by a small behavioural FIFO with registered read data.
module tb_mic_frame_ctrl;

`ifdef MICCTRL_DROPCNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: FRAME_LEN=4
  logic        en_a, full_a, mic_a, clr_a, ready_a;
  logic        rd_a, busy_a, ovf_a, empty_a;
  logic [15:0] dout_a, fcnt_a, drop_a;
  logic [15:0] mem_a [0:127];
  int          wp_a, rp_a;

  assign empty_a = (wp_a == rp_a);
  always @(posedge clk) begin
    if (rd_a) begin
      dout_a <= mem_a[rp_a % 128];
      rp_a   <= rp_a + 1;
    end
  end

  mic_frame_ctrl_if #(.DATA_W(16)) sa ();
  assign sa.out_ready = ready_a;

  mic_frame_ctrl #(.DATA_W(16), .FRAME_LEN(4), .CNT_W(16)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .enable     (en_a),
    .fifo_empty (empty_a),
    .fifo_full  (full_a),
    .mic_wr_en  (mic_a),
    .fifo_dout  (dout_a),
    .fifo_rd_en (rd_a),
    .stream     (sa),
    .busy       (busy_a),
    .frame_cnt  (fcnt_a),
    .ovf_flag   (ovf_a),
    .ovf_clr    (clr_a),
    .drop_cnt   (drop_a)
  );

  // Instance B: FRAME_LEN=1
  logic        rd_b, busy_b, ovf_b, empty_b;
  logic [15:0] dout_b, fcnt_b, drop_b;
  logic [15:0] mem_b [0:127];
  int          wp_b, rp_b;

  assign empty_b = (wp_b == rp_b);
  always @(posedge clk) begin
    if (rd_b) begin
      dout_b <= mem_b[rp_b % 128];
      rp_b   <= rp_b + 1;
    end
  end

  mic_frame_ctrl_if #(.DATA_W(16)) sb ();
  assign sb.out_ready = 1'b1;

  mic_frame_ctrl #(.DATA_W(16), .FRAME_LEN(1), .CNT_W(16)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .enable     (1'b1),
    .fifo_empty (empty_b),
    .fifo_full  (1'b0),
    .mic_wr_en  (1'b0),
    .fifo_dout  (dout_b),
    .fifo_rd_en (rd_b),
    .stream     (sb),
    .busy       (busy_b),
    .frame_cnt  (fcnt_b),
    .ovf_flag   (ovf_b),
    .ovf_clr    (1'b0),
    .drop_cnt   (drop_b)
  );

  // Handshake logs and protocol monitors, sampled on the falling edge
  logic [15:0] la_d[$];
  logic        la_s[$];
  logic        la_e[$];
  logic [15:0] la_f[$];
  int          la_t[$];
  logic [15:0] lb_d[$];
  logic        lb_s[$];
  logic        lb_e[$];
  int          rd_bad, lat_bad, t_rd;
  logic        v_prev = 1'b0;

  always @(negedge clk) begin
    if (sa.out_valid && ready_a) begin
      la_d.push_back(sa.out_data);
      la_s.push_back(sa.out_sof);
      la_e.push_back(sa.out_eof);
      la_f.push_back(fcnt_a);
      la_t.push_back(cyc);
    end
    if (sb.out_valid) begin
      lb_d.push_back(sb.out_data);
      lb_s.push_back(sb.out_sof);
      lb_e.push_back(sb.out_eof);
    end
    if (rd_a && (empty_a || sa.out_valid)) rd_bad++;
    if (rd_a) t_rd = cyc;
    if (sa.out_valid && !v_prev && (cyc - t_rd != 2)) lat_bad++;
    v_prev = sa.out_valid;
  end

  typedef struct {
    logic [15:0] din;
    logic [15:0] data;
    logic        sof;
    logic        eof;
    logic [15:0] fcnt;
  } vec_t;
  vec_t tv [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_a(input logic [15:0] v);
    mem_a[wp_a % 128] = v;
    wp_a++;
  endtask

  task automatic push_b(input logic [15:0] v);
    mem_b[wp_b % 128] = v;
    wp_b++;
  endtask

  task automatic wait_log_a(input int n, input int budget);
    int k = 0;
    while (la_d.size() < n && k < budget) begin
      step();
      k++;
    end
    check($sformatf("handshakes_a_reach_%0d", n), la_d.size(), n);
  endtask

  task automatic wait_valid_a(input int budget);
    int k = 0;
    while (!sa.out_valid && k < budget) begin
      step();
      k++;
    end
    check("wait_valid_a", sa.out_valid, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'd0};
    tv[1] = '{16'h0002, 16'h0002, 1'b0, 1'b0, 16'd0};
    tv[2] = '{16'h0003, 16'h0003, 1'b0, 1'b0, 16'd0};
    tv[3] = '{16'h0004, 16'h0004, 1'b0, 1'b1, 16'd0};
    tv[4] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'd1};
    tv[5] = '{16'h0006, 16'h0006, 1'b0, 1'b0, 16'd1};
    tv[6] = '{16'h0007, 16'h0007, 1'b0, 1'b0, 16'd1};
    tv[7] = '{16'h0008, 16'h0008, 1'b0, 1'b1, 16'd1};

    rst = 1'b1; en_a = 1'b0; full_a = 1'b0; mic_a = 1'b0; clr_a = 1'b0; ready_a = 1'b0;
    repeat (3) step();
    check("rst_rd_en", rd_a, 0);
    check("rst_valid", sa.out_valid, 0);
    check("rst_data", sa.out_data, 0);
    check("rst_sof_eof", {sa.out_sof, sa.out_eof}, 0);
    check("rst_busy", busy_a, 0);
    check("rst_frame_cnt", fcnt_a, 0);
    check("rst_ovf_drop", {ovf_a, drop_a}, 0);
    rst = 1'b0;
    step();

    // Two back-to-back frames from a preloaded FIFO
    for (int i = 0; i < 8; i++) push_a(tv[i].din);
    en_a = 1'b1;
    ready_a = 1'b1;
    wait_log_a(8, 100);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_data%0d", i), la_d[i], tv[i].data);
      check($sformatf("t1_sof%0d", i), la_s[i], tv[i].sof);
      check($sformatf("t1_eof%0d", i), la_e[i], tv[i].eof);
      check($sformatf("t1_fcnt%0d", i), la_f[i], tv[i].fcnt);
    end
    check("t1_throughput", la_t[1] - la_t[0], 3);
    step(); step();
    check("t1_frame_cnt", fcnt_a, 2);
    check("t1_busy_after", busy_a, 0);

    // Back-pressure on the second sample
    ready_a = 1'b0;
    push_a(16'h0011); push_a(16'h0012); push_a(16'h0013); push_a(16'h0014);
    wait_valid_a(20);
    ready_a = 1'b1;
    step();
    ready_a = 1'b0;
    wait_valid_a(20);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t2_stall%0d", i),
            {sa.out_data, sa.out_sof, sa.out_eof, rd_a, sa.out_valid},
            {16'h0012, 1'b0, 1'b0, 1'b0, 1'b1});
      step();
    end
    ready_a = 1'b1;
    wait_log_a(12, 50);
    check("t2_sof_first", la_s[8], 1);
    check("t2_data_s2", la_d[9], 16'h0012);
    check("t2_data_s3", la_d[10], 16'h0013);
    check("t2_eof_s4", {la_d[11], la_e[11]}, {16'h0014, 1'b1});
    step(); step();
    check("t2_frame_cnt", fcnt_a, 3);

    // FIFO runs dry mid-frame with enable dropped
    push_a(16'h0021); push_a(16'h0022);
    step(); step();
    en_a = 1'b0;
    wait_log_a(14, 50);
    repeat (5) step();
    check("t3_wait_busy", busy_a, 1);
    check("t3_wait_idle_out", {sa.out_valid, rd_a}, 0);
    push_a(16'h0023); push_a(16'h0024);
    wait_log_a(16, 50);
    check("t3_sof", la_s[12], 1);
    check("t3_eof_s4", {la_d[15], la_s[15], la_e[15]}, {16'h0024, 1'b0, 1'b1});
    step(); step();
    check("t3_idle_busy", busy_a, 0);
    check("t3_frame_cnt", fcnt_a, 4);

    // enable low keeps the FSM idle even with data waiting
    push_a(16'h0031);
    repeat (5) step();
    check("t4_hold_busy", busy_a, 0);
    check("t4_hold_nolog", la_d.size(), 16);

    // Asynchronous reset while presenting the second sample of a frame
    push_a(16'h0032); push_a(16'h0033);
    en_a = 1'b1;
    wait_valid_a(20);
    check("t5_first", {sa.out_data, sa.out_sof}, {16'h0031, 1'b1});
    ready_a = 1'b1;
    step();
    ready_a = 1'b0;
    wait_valid_a(20);
    check("t5_present", sa.out_data, 16'h0032);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", sa.out_valid, 0);
    check("t5_rst_data", sa.out_data, 0);
    check("t5_rst_flags", {sa.out_sof, sa.out_eof, busy_a, rd_a}, 0);
    check("t5_rst_frame_cnt", fcnt_a, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    ready_a = 1'b1;
    wait_log_a(18, 50);
    check("t5_next_sof", {la_d[17], la_s[17], la_e[17]}, {16'h0033, 1'b1, 1'b0});
    check("t5_next_fcnt", la_f[17], 0);
    en_a = 1'b0;

    // Overflow flag and drop counter
    check("t6_ovf_init", ovf_a, 0);
    full_a = 1'b1;
    mic_a = 1'b1;
    step();
    check("t6_ovf_next_cycle", ovf_a, 1);
    step(); step();
    mic_a = 1'b0;
    check("t6_ovf_set", ovf_a, 1);
    check("t6_drop3", drop_a, DROP_EN ? 3 : 0);
    mic_a = 1'b1;
    clr_a = 1'b1;
    step();
    mic_a = 1'b0;
    clr_a = 1'b0;
    check("t6_set_wins", ovf_a, 1);
    check("t6_drop_clr_inc", drop_a, DROP_EN ? 1 : 0);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    full_a = 1'b0;
    check("t6_ovf_cleared", ovf_a, 0);
    check("t6_drop_cleared", drop_a, 0);

    // FRAME_LEN=1: every sample is a whole frame
    push_b(16'h0041); push_b(16'h0042); push_b(16'h0043);
    begin
      int k = 0;
      while (lb_d.size() < 3 && k < 60) begin
        step();
        k++;
      end
    end
    check("t7_handshakes", lb_d.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t7_sample%0d", i), {lb_d[i], lb_s[i], lb_e[i]},
            {16'h0041 + 16'(i), 1'b1, 1'b1});
    end
    step(); step();
    check("t7_frame_cnt", fcnt_b, 3);

    check("mon_rd_guard", rd_bad, 0);
    check("mon_latency", lat_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
